// File: rtl/comet_ii_pkg.sv
// Shared types and constants for the COMET II memory arbiter slice.
package comet_ii_pkg;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;
endpackage

// File: rtl/comet_ii_rr_pick.sv
// Two-way round-robin winner select with a bounded host lock override.
module comet_ii_rr_pick
  import comet_ii_pkg::*;
(
  input  logic   cpu_req,
  input  logic   host_req,
  input  logic   host_lock,
  input  owner_t last_owner,
  input  logic   lock_expired,
  output owner_t winner
);

  always_comb begin
    winner = OWN_CPU;
    if (cpu_req && !host_req) begin
      winner = OWN_CPU;
    end else if (host_req && !cpu_req) begin
      winner = OWN_HOST;
    end else if (host_lock && (last_owner == OWN_HOST) && !lock_expired) begin
      winner = OWN_HOST;
    end else begin
      winner = (last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
    end
  end

endmodule

// File: rtl/comet_ii_mem_arbiter.sv
// Single-port main memory arbiter between the CPU controller and the host loader.
module comet_ii_mem_arbiter
  import comet_ii_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_adr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [WORD_W-1:0] host_adr,
  input  logic [WORD_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [WORD_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_adr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

  arb_state_t     state, state_nxt;
  logic [1:0]     lat_cnt;
  owner_t         rd_owner, last_owner, winner;
  logic [LCW-1:0] lock_cnt;
  logic           rd_done, grant_ok, gnt, lock_expired;

  assign rd_done      = (state == RD_WAIT) && (lat_cnt == 2'd0);
  // Grants are combinational from the requests, so gate them with reset to
  // keep every output at its reset value while reset is held.
  assign grant_ok     = rst && ((state == IDLE) || rd_done);
  assign gnt          = grant_ok && (cpu_req || host_req);
  assign lock_expired = (lock_cnt >= LCW'(LOCK_MAX));

  comet_ii_rr_pick u_pick (
    .cpu_req      (cpu_req),
    .host_req     (host_req),
    .host_lock    (host_lock),
    .last_owner   (last_owner),
    .lock_expired (lock_expired),
    .winner       (winner)
  );

  always_comb begin
    state_nxt = state;
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state)
      IDLE:    state_nxt = IDLE;
      RD_WAIT: state_nxt = (lat_cnt == 2'd0) ? IDLE : RD_WAIT;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (gnt) begin
      mem_en = 1'b1;
      if (winner == OWN_CPU) begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we;
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
      end else begin
        host_gnt  = 1'b1;
        mem_we    = host_we;
        mem_adr   = host_adr;
        mem_wdata = host_wdata;
      end
      state_nxt = mem_we ? WR : RD_WAIT;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      rd_owner   <= OWN_CPU;
      last_owner <= OWN_HOST;
      lock_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (gnt && !mem_we) begin
        lat_cnt  <= 2'(MEM_LAT - 1);
        rd_owner <= winner;
      end else if ((state == RD_WAIT) && (lat_cnt != 2'd0)) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (gnt) begin
        last_owner <= winner;
      end
      if (!host_lock || cpu_gnt) begin
        lock_cnt <= '0;
      end else if (host_gnt && cpu_req && !lock_expired) begin
        lock_cnt <= lock_cnt + LCW'(1);
      end
    end
  end

  assign cpu_rvalid  = rd_done && (rd_owner == OWN_CPU);
  assign host_rvalid = rd_done && (rd_owner == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign cpu_stall   = rst && cpu_req && !cpu_gnt;

endmodule

// File: tb/tb_comet_ii_mem_arbiter.sv
// Directed self-checking bench: three arbiters (MEM_LAT 1, 3, 4) share stimulus.
module tb_comet_ii_mem_arbiter;

  logic        mclk = 1'b0;
  logic        rst  = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [15:0] cpu_adr = '0, cpu_wdata = '0, host_adr = '0, host_wdata = '0;

  logic        cpu_gnt_o [3];
  logic        cpu_rvalid_o [3];
  logic [15:0] cpu_rdata_o [3];
  logic        host_gnt_o [3];
  logic        host_rvalid_o [3];
  logic [15:0] host_rdata_o [3];
  logic        mem_en_o [3];
  logic        mem_we_o [3];
  logic [15:0] mem_adr_o [3];
  logic [15:0] mem_wdata_o [3];
  logic [15:0] mem_rdata_i [3];
  logic        cpu_stall_o [3];

  logic [15:0] mem [3][256];
  logic [7:0]  pipe [3][4];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned stall_cnt;

  always #5 mclk = ~mclk;

  comet_ii_mem_arbiter #(.MEM_LAT(1), .LOCK_MAX(8)) u_lat1 (
    .mclk(mclk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_o[0]), .cpu_rvalid(cpu_rvalid_o[0]), .cpu_rdata(cpu_rdata_o[0]),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt_o[0]), .host_rvalid(host_rvalid_o[0]), .host_rdata(host_rdata_o[0]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_adr(mem_adr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0]), .cpu_stall(cpu_stall_o[0])
  );

  comet_ii_mem_arbiter #(.MEM_LAT(3), .LOCK_MAX(8)) u_lat3 (
    .mclk(mclk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_o[1]), .cpu_rvalid(cpu_rvalid_o[1]), .cpu_rdata(cpu_rdata_o[1]),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt_o[1]), .host_rvalid(host_rvalid_o[1]), .host_rdata(host_rdata_o[1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_adr(mem_adr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1]), .cpu_stall(cpu_stall_o[1])
  );

  comet_ii_mem_arbiter #(.MEM_LAT(4), .LOCK_MAX(8)) u_lat4 (
    .mclk(mclk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_o[2]), .cpu_rvalid(cpu_rvalid_o[2]), .cpu_rdata(cpu_rdata_o[2]),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt_o[2]), .host_rvalid(host_rvalid_o[2]), .host_rdata(host_rdata_o[2]),
    .mem_en(mem_en_o[2]), .mem_we(mem_we_o[2]), .mem_adr(mem_adr_o[2]),
    .mem_wdata(mem_wdata_o[2]), .mem_rdata(mem_rdata_i[2]), .cpu_stall(cpu_stall_o[2])
  );

  // Memory model: word at address a initialises to 0x1000+a; read data appears
  // MEM_LAT cycles after the command through an address pipeline.
  always @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int a = 0; a < 256; a++) mem[i][a] <= 16'h1000 + 16'(a);
        for (int k = 0; k < 4; k++) pipe[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mem_en_o[i] && mem_we_o[i]) mem[i][mem_adr_o[i][7:0]] <= mem_wdata_o[i];
        pipe[i][0] <= mem_adr_o[i][7:0];
        for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
      end
    end
  end

  assign mem_rdata_i[0] = mem[0][pipe[0][0]];
  assign mem_rdata_i[1] = mem[1][pipe[1][2]];
  assign mem_rdata_i[2] = mem[2][pipe[2][3]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_wdata = '0; host_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge mclk);
    rst = 1'b1;
  endtask

  // Advance to the next cycle; inputs are changed right after the falling edge.
  task automatic next_cyc();
    @(negedge mclk);
  endtask

  task automatic check_all_zero(input int unsigned d, input string tag);
    chk({tag, "_gnt"}, {30'd0, cpu_gnt_o[d], host_gnt_o[d]}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, cpu_rvalid_o[d], host_rvalid_o[d]}, 32'd0);
    chk({tag, "_rdata"}, {cpu_rdata_o[d], host_rdata_o[d]}, 32'd0);
    chk({tag, "_mem_cmd"}, {30'd0, mem_en_o[d], mem_we_o[d]}, 32'd0);
    chk({tag, "_mem_bus"}, {mem_adr_o[d], mem_wdata_o[d]}, 32'd0);
  endtask

  initial begin
    // Reset state and a single CPU read, MEM_LAT=1.
    repeat (2) @(negedge mclk);
    #2 check_all_zero(0, "rst1");
    rst = 1'b1;
    next_cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0010;
    #2;
    chk("rd1_cpu_gnt", 32'(cpu_gnt_o[0]), 32'd1);
    chk("rd1_mem_adr", 32'(mem_adr_o[0]), 32'h0010);
    chk("rd1_mem_en_we", {30'd0, mem_en_o[0], mem_we_o[0]}, 32'b10);
    chk("rd1_stall", 32'(cpu_stall_o[0]), 32'd0);
    next_cyc();
    cpu_req = 1'b0;
    #2;
    chk("rd1_cpu_rvalid", 32'(cpu_rvalid_o[0]), 32'd1);
    chk("rd1_cpu_rdata", 32'(cpu_rdata_o[0]), 32'h1010);
    chk("rd1_host_rvalid", 32'(host_rvalid_o[0]), 32'd0);
    next_cyc();
    #2 chk("rd1_rvalid_once", 32'(cpu_rvalid_o[0]), 32'd0);

    // Round robin: continuous reads from both ports, no lock.
    do_reset();
    cpu_req = 1'b1; host_req = 1'b1; cpu_adr = 16'h0001; host_adr = 16'h0002;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("rr_cpu_gnt%0d", k), 32'(cpu_gnt_o[0]), 32'((k % 2) == 0));
      chk($sformatf("rr_host_gnt%0d", k), 32'(host_gnt_o[0]), 32'((k % 2) == 1));
      next_cyc();
    end

    // Host lock: 8 consecutive host grants, then the CPU.
    do_reset();
    cpu_req = 1'b1; host_req = 1'b1; host_lock = 1'b1;
    stall_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      #2;
      chk($sformatf("lock_host_gnt%0d", k), 32'(host_gnt_o[0]), 32'(k < 8));
      chk($sformatf("lock_cpu_gnt%0d", k), 32'(cpu_gnt_o[0]), 32'(k == 8));
      if (cpu_stall_o[0]) stall_cnt++;
      next_cyc();
    end
    chk("lock_stall_cycles", stall_cnt, 32'd8);

    // MEM_LAT=3: CPU read then host write.
    do_reset();
    cpu_req = 1'b1; cpu_adr = 16'h0030;
    host_req = 1'b1; host_we = 1'b1; host_adr = 16'h0040; host_wdata = 16'h1234;
    #2;
    chk("lat3_cpu_gnt", {30'd0, cpu_gnt_o[1], host_gnt_o[1]}, 32'b10);
    next_cyc();
    cpu_req = 1'b0;
    for (int k = 1; k < 3; k++) begin
      #2;
      chk($sformatf("lat3_host_wait%0d", k), 32'(host_gnt_o[1]), 32'd0);
      chk($sformatf("lat3_no_rvalid%0d", k), 32'(cpu_rvalid_o[1]), 32'd0);
      next_cyc();
    end
    #2;
    chk("lat3_cpu_rvalid", 32'(cpu_rvalid_o[1]), 32'd1);
    chk("lat3_cpu_rdata", 32'(cpu_rdata_o[1]), 32'h1030);
    chk("lat3_host_gnt", 32'(host_gnt_o[1]), 32'd1);
    chk("lat3_mem_wr", {15'd0, mem_we_o[1], mem_wdata_o[1]}, 32'h0001_1234);
    next_cyc();
    host_req = 1'b0;

    // CPU write then host read-back through the WR recovery slot.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0020; cpu_wdata = 16'hBEEF;
    host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0020;
    #2;
    chk("wr_cpu_gnt", {30'd0, cpu_gnt_o[0], host_gnt_o[0]}, 32'b10);
    chk("wr_mem_we", {15'd0, mem_we_o[0], mem_wdata_o[0]}, 32'h0001_BEEF);
    next_cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    chk("wr_slot_host_gnt", 32'(host_gnt_o[0]), 32'd0);
    chk("wr_slot_mem_cmd", {30'd0, mem_en_o[0], mem_we_o[0]}, 32'd0);
    next_cyc();
    #2;
    chk("wr_host_gnt", 32'(host_gnt_o[0]), 32'd1);
    chk("wr_host_rd_cmd", {15'd0, mem_we_o[0], mem_adr_o[0]}, 32'h0000_0020);
    next_cyc();
    host_req = 1'b0;
    #2;
    chk("wr_host_rvalid", 32'(host_rvalid_o[0]), 32'd1);
    chk("wr_host_rdata", 32'(host_rdata_o[0]), 32'hBEEF);

    // MEM_LAT=4: reset in the middle of a read.
    do_reset();
    cpu_req = 1'b1; cpu_adr = 16'h0050;
    #2 chk("rst4_cpu_gnt", 32'(cpu_gnt_o[2]), 32'd1);
    next_cyc();
    cpu_req = 1'b0;
    next_cyc();
    cpu_req = 1'b1; host_req = 1'b1;
    #2 chk("rst4_stall_pre", 32'(cpu_stall_o[2]), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero(2, "rst4");
    chk("rst4_stall", 32'(cpu_stall_o[2]), 32'd0);
    next_cyc();
    cpu_req = 1'b0; host_req = 1'b0;
    next_cyc();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2 chk($sformatf("rst4_no_rvalid%0d", k),
             {30'd0, cpu_rvalid_o[2], host_rvalid_o[2]}, 32'd0);
      next_cyc();
    end
    cpu_req = 1'b1; host_req = 1'b1;
    #2 chk("rst4_first_tie", {30'd0, cpu_gnt_o[2], host_gnt_o[2]}, 32'b10);
    next_cyc();
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/comet_ii_mem_arbiter.md
# comet_ii_mem_arbiter

Arbitrates the single-port COMET II main memory between the CPU controller (instruction fetch and operand load/store) and the host loader/debug port. It serializes accesses with a request/grant handshake, enforces the memory read latency, and applies round-robin fairness with a bounded host lock for atomic multi-word transfers. It sits between the CPU controller's `adr`/`adr_en`/`rdata` path and the memory macro.

## Interface
- `MEM_LAT`, default 1: memory read latency in cycles, from `mem_en` to valid `mem_rdata`; legal range 1..4.
- `LOCK_MAX`, default 8: maximum number of consecutive host grants under `host_lock` while `cpu_req` is pending.
- `mclk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cpu_req` input 1: CPU access request; held until `cpu_gnt`.
- `cpu_we` input 1: CPU write (1) or read (0).
- `cpu_adr` input 16: CPU word address.
- `cpu_wdata` input 16: CPU write data.
- `cpu_gnt` output 1: one-cycle grant; CPU address, data and `we` are sampled in this cycle.
- `cpu_rvalid` output 1: CPU read data valid.
- `cpu_rdata` output 16: CPU read data.
- `host_req`, `host_we`, `host_adr[15:0]`, `host_wdata[15:0]` inputs: host request, same rules as the CPU port.
- `host_lock` input 1: the host requests to keep ownership for its next transaction.
- `host_gnt`, `host_rvalid` outputs 1; `host_rdata` output 16: same rules as the CPU port.
- `mem_en`, `mem_we` outputs 1; `mem_adr`, `mem_wdata` outputs 16: memory command.
- `mem_rdata` input 16: memory read data.
- `cpu_stall` output 1: high while `cpu_req` is high and `cpu_gnt` is low; the CPU FSM holds its stage.

## Operation
- States:
  - IDLE: no access in flight.
  - RD_WAIT: read outstanding; a latency counter runs from MEM_LAT-1 down to 0.
  - WR: single-cycle write slot.
- Grant occurs only in IDLE, or in the final RD_WAIT cycle (counter = 0), when at least one request is present. Exactly one of `cpu_gnt`/`host_gnt` is high. The grant cycle drives `mem_en`=1 with the granted port's `adr`/`we`/`wdata`, combinationally muxed from the winner.
- Winner selection:
  - Only one requester: that requester wins.
  - Both requesting, `host_lock`=1, last owner = host, and `lock_cnt` < LOCK_MAX: host wins.
  - Otherwise the port that is not the last owner wins (round robin).
- `lock_cnt` increments on each host grant made while `host_lock`=1 and `cpu_req`=1. It clears on any CPU grant and whenever `host_lock`=0. It saturates at LOCK_MAX.
- After a grant, the next state is RD_WAIT for a read or WR for a write. From WR, the next state is IDLE, or a new grant is issued that cycle's successor. When RD_WAIT reaches 0 with no request, the next state is IDLE.
- Read return: `*_rvalid` is high for exactly one cycle, MEM_LAT cycles after the grant, on the port that owned the read. `*_rdata` = `mem_rdata` in that cycle and 0 otherwise.
- `mem_we` and `mem_wdata` are 0 when `mem_en`=0.

## Timing
- Reset values: all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` = 0; `*_rdata`, `mem_adr`, `mem_wdata` = 0; state = IDLE; last owner = host, so the CPU wins the first tie; `lock_cnt` = 0.
- Latency: a request presented in IDLE is granted in the same cycle.
- Read with grant at cycle T: `rvalid` at T+MEM_LAT. The next grant is at the earliest T+MEM_LAT, overlapping the `rvalid` cycle.
- Write with grant at cycle T: the next grant is at the earliest T+2. This leaves a one-cycle WR slot for memory write recovery.
- Back-to-back CPU reads with MEM_LAT=1 sustain one grant per cycle.
- A request dropped before grant is legal; no access occurs.
- Changing `adr`, `we` or `wdata` while a request is pending is legal; the values in the grant cycle are used.
- Reset asserted mid-read: the read is abandoned, no `rvalid` is ever issued, and all outputs reach reset values asynchronously.
- `host_lock` without `host_req` has no effect.

## Structure
- The shared package `comet_ii_pkg` holds:
  - `arb_state_t` enum (IDLE, RD_WAIT, WR).
  - `owner_t` enum (OWN_CPU, OWN_HOST).
  - Constant `WORD_W` = 16.
- Sub-module `comet_ii_rr_pick`: a combinational two-way round-robin and lock-priority selector. Inputs are `cpu_req`, `host_req`, `host_lock`, last owner and lock-expired; output is the winner. The FSM, latency counter, owner-of-read register and `lock_cnt` live in the top module.

## Test plan
- Reset, then `cpu_req` read at address 0x0010 with MEM_LAT=1: `cpu_gnt` in the same cycle, `mem_adr`=0x0010, `cpu_rvalid` one cycle later with `cpu_rdata` = memory contents; `host_rvalid` stays 0.
- Both ports request a read every cycle, `host_lock`=0: grants alternate CPU, host, CPU, host…, starting with CPU after reset.
- Host holds `host_lock`=1 with continuous `host_req` and `cpu_req`, LOCK_MAX=8: host receives 8 consecutive grants, CPU gets the 9th grant, and `cpu_stall` is high for exactly those 8 cycles.
- MEM_LAT=3, CPU read followed by a host write request: `host_gnt` is no earlier than 3 cycles after `cpu_gnt`, and `cpu_rvalid` arrives exactly 3 cycles after `cpu_gnt`.
- CPU write of 0xBEEF to address 0x0020 with `host_req` pending: `mem_we`=1 for one cycle, `host_gnt` 2 cycles later, and a host read of 0x0020 returns 0xBEEF.
- Reset asserted during RD_WAIT with MEM_LAT=4: all outputs go to 0 immediately, no `rvalid` appears after reset release, and the first tie after reset goes to the CPU.
